// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle control sequencer for the 9-bit ISA. It latches
//               the fetched instruction and steps through FETCH/DECODE/EXEC/
//               MEM/WB. It drives the PC, register-file, ALU and data-memory
//               enables for each state and counts retired instructions with
//               a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int INSTR_W = 9,
    parameter int OPC_W   = 4,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic               BranchFlag,
    output logic               IrLoad,
    output logic               PcInc,
    output logic               BranchEn,
    output logic               ALUEn,
    output logic               MemRdEn,
    output logic               MemWrEn,
    output logic               RegWrEn,
    output logic               Ack,
    output logic               Busy,
    output logic [2:0]         State,
    output logic [CNT_W-1:0]   InstrCount
);

    // State encoding is visible on the State debug port.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // Opcode map
    localparam logic [OPC_W-1:0] c_OP_LW  = OPC_W'(0);
    localparam logic [OPC_W-1:0] c_OP_LWL = OPC_W'(1);
    localparam logic [OPC_W-1:0] c_OP_SW  = OPC_W'(2);
    localparam logic [OPC_W-1:0] c_OP_SWL = OPC_W'(3);
    localparam logic [OPC_W-1:0] c_OP_XOR = OPC_W'(4);
    localparam logic [OPC_W-1:0] c_OP_ADD = OPC_W'(5);
    localparam logic [OPC_W-1:0] c_OP_LSR = OPC_W'(6);
    localparam logic [OPC_W-1:0] c_OP_LSL = OPC_W'(7);
    localparam logic [OPC_W-1:0] c_OP_MOV = OPC_W'(8);
    localparam logic [OPC_W-1:0] c_OP_SNE = OPC_W'(9);
    localparam logic [OPC_W-1:0] c_OP_SEQ = OPC_W'(10);
    localparam logic [OPC_W-1:0] c_OP_BOO = OPC_W'(11);
    localparam logic [OPC_W-1:0] c_OP_LUT = OPC_W'(12);
    localparam logic [OPC_W-1:0] c_OP_BOL = OPC_W'(13);
    localparam logic [OPC_W-1:0] c_OP_MSK = OPC_W'(14);
    localparam logic [OPC_W-1:0] c_OP_EXT = OPC_W'(15);

    // The latency counter runs 0 .. MEM_LAT-1 while a load sits in MEM.
    localparam int                 c_LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(MEM_LAT - 1);

    state_t             r_state;
    logic [INSTR_W-1:0] r_ir;
    logic [c_LAT_W-1:0] r_lat;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_start_d;

    logic [OPC_W-1:0]   w_opc;
    logic               w_halt;
    logic               w_start_edge;
    logic               w_retire;
    logic               w_is_alu;
    logic               w_is_br;
    logic               w_is_bol;
    logic               w_is_ld;
    logic               w_is_st;
    logic               w_is_mov;
    logic               w_is_nop;

    assign w_opc        = r_ir[INSTR_W-1 -: OPC_W];
    assign w_halt       = &r_ir;
    assign w_start_edge = Start & ~r_start_d;
    assign w_retire     = PcInc | BranchEn;

    // Classify the latched instruction into its execution class.
    always_comb begin
        w_is_alu = 1'b0;
        w_is_br  = 1'b0;
        w_is_bol = 1'b0;
        w_is_ld  = 1'b0;
        w_is_st  = 1'b0;
        w_is_mov = 1'b0;
        w_is_nop = 1'b0;
        case (w_opc)
            c_OP_XOR, c_OP_ADD, c_OP_LSR, c_OP_LSL,
            c_OP_SNE, c_OP_SEQ, c_OP_MSK: w_is_alu = 1'b1;
            c_OP_BOO:                     w_is_br  = 1'b1;
            c_OP_BOL: begin
                w_is_br  = 1'b1;
                w_is_bol = 1'b1;
            end
            c_OP_LW, c_OP_LWL:            w_is_ld  = 1'b1;
            c_OP_SW, c_OP_SWL:            w_is_st  = 1'b1;
            c_OP_MOV:                     w_is_mov = 1'b1;
            c_OP_LUT, c_OP_EXT:           w_is_nop = ~w_halt;
            // Unmapped opcodes (only possible with a wider opcode field)
            // are retired as NOPs so the PC keeps moving.
            default:                      w_is_nop = ~w_halt;
        endcase
    end

    // Decode the control strobes from registered state and IR. Only the
    // boo PC selection looks at the live BranchFlag.
    always_comb begin
        IrLoad   = 1'b0;
        PcInc    = 1'b0;
        BranchEn = 1'b0;
        ALUEn    = 1'b0;
        MemRdEn  = 1'b0;
        MemWrEn  = 1'b0;
        RegWrEn  = 1'b0;
        Ack      = 1'b0;
        Busy     = 1'b0;
        case (r_state)
            S_FETCH: begin
                Busy   = 1'b1;
                IrLoad = 1'b1;
            end
            S_DECODE: begin
                Busy  = 1'b1;
                PcInc = w_is_nop;
            end
            S_EXEC: begin
                Busy  = 1'b1;
                ALUEn = w_is_alu;
                if (w_is_bol) begin
                    BranchEn = 1'b1;
                end else if (w_is_br) begin
                    BranchEn = BranchFlag;
                    PcInc    = ~BranchFlag;
                end
            end
            S_MEM: begin
                Busy    = 1'b1;
                MemWrEn = w_is_st;
                PcInc   = w_is_st;
                MemRdEn = w_is_ld;
            end
            S_WB: begin
                Busy    = 1'b1;
                RegWrEn = 1'b1;
                PcInc   = 1'b1;
                ALUEn   = w_is_alu;
            end
            S_DONE: begin
                Ack = 1'b1;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

    // Sequencer, instruction register, load latency counter and retire counter.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_lat     <= '0;
            r_cnt     <= '0;
            r_start_d <= 1'b0;
        end else begin
            r_start_d <= Start;

            // Retirement happens in the last cycle of each instruction, and
            // never in IDLE/DONE, so it cannot collide with the restart clear.
            if (w_retire && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_edge) begin
                        r_state <= S_FETCH;
                        r_cnt   <= '0;
                    end
                end
                S_FETCH: begin
                    r_ir    <= Instruction;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (w_halt) begin
                        r_state <= S_DONE;
                    end else if (w_is_nop) begin
                        r_state <= S_FETCH;
                    end else if (w_is_alu || w_is_br) begin
                        r_state <= S_EXEC;
                    end else if (w_is_ld || w_is_st) begin
                        r_state <= S_MEM;
                        r_lat   <= '0;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_EXEC: begin
                    r_state <= w_is_br ? S_FETCH : S_WB;
                end
                S_MEM: begin
                    if (w_is_st) begin
                        r_state <= S_FETCH;
                    end else if (r_lat == c_LAT_LAST) begin
                        r_state <= S_WB;
                    end else begin
                        r_lat <= r_lat + c_LAT_W'(1);
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign State      = r_state;
    assign InstrCount = r_cnt;

endmodule
`default_nettype wire
